// File: rtl/spectrum_frame_ctrl.sv
// Spectrum frame controller: captures FFT magnitude frames (optionally max-decimated)
// into a ping-pong buffer and serves display columns to the LCD renderer.
module spectrum_frame_ctrl #(
    parameter  int unsigned DATA_W      = 16,
    parameter  int unsigned FFT_LEN     = 128,
    parameter  int unsigned DECIM       = 1,
    parameter  int unsigned DECAY_SHIFT = 3,
    localparam int unsigned COLS        = FFT_LEN / 2 / DECIM,
    localparam int unsigned CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] fft_data,
    input  logic              fft_sop,
    input  logic              fft_eop,
    input  logic              fft_valid,
    input  logic [1:0]        mode,
    input  logic              data_req,
    input  logic              wr_over,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CW-1:0]     rd_cnt,
    output logic              frame_ready,
    output logic              frame_drop,
    output logic              frame_err
);

    localparam int unsigned   SW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(DECIM - 1);

    typedef enum logic [1:0] {W_IDLE, W_CAP, W_SKIP, W_HOLD} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_WAIT} rstate_e;

    wstate_e           wstate_q;
    rstate_e           rstate_q;
    logic [DATA_W-1:0] bank_q [2][COLS];
    logic              front_q;
    logic              ready_q;
    logic              peak_q;
    logic [CW-1:0]     col_q;
    logic [SW-1:0]     sub_q;
    logic [DATA_W-1:0] max_q;
    logic [CW-1:0]     rd_cnt_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              drop_q;
    logic              err_q;

    logic              swap;
    logic              front_d;
    logic              start;
    logic              take;
    logic              peak_d;
    logic              last_bin;
    logic [CW-1:0]     beat_col;
    logic [SW-1:0]     beat_sub;
    logic [DATA_W-1:0] grp_max;
    logic [DATA_W-1:0] front_val;
    logic [DATA_W-1:0] decayed;
    logic [DATA_W-1:0] col_val;

    // A sop beat is always bin 0, so its position overrides the stored counters.
    always_comb begin
        swap      = ready_q && (rstate_q == R_IDLE) && (rd_cnt_q == '0);
        front_d   = swap ? ~front_q : front_q;
        start     = fft_valid && fft_sop &&
                    ((wstate_q == W_CAP) || ((wstate_q == W_IDLE) && (mode != 2'd2)));
        take      = start || (fft_valid && (wstate_q == W_CAP));
        beat_col  = start ? '0 : col_q;
        beat_sub  = start ? '0 : sub_q;
        peak_d    = start ? (mode == 2'd1) : peak_q;
        grp_max   = ((beat_sub == '0) || (fft_data > max_q)) ? fft_data : max_q;
        front_val = bank_q[front_q][beat_col];
        decayed   = front_val - (front_val >> DECAY_SHIFT);
        col_val   = (peak_d && (decayed > grp_max)) ? decayed : grp_max;
        last_bin  = (beat_col == COL_LAST) && (beat_sub == SUB_LAST);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wstate_q <= W_IDLE;
            front_q  <= 1'b0;
            ready_q  <= 1'b0;
            peak_q   <= 1'b0;
            col_q    <= '0;
            sub_q    <= '0;
            max_q    <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    bank_q[b][c] <= '0;
                end
            end
        end else begin
            drop_q <= 1'b0;
            err_q  <= 1'b0;
            if (swap) begin
                front_q <= ~front_q;
                ready_q <= 1'b0;
            end
            case (wstate_q)
                W_IDLE, W_CAP: begin
                    if (take) begin
                        peak_q <= peak_d;
                        max_q  <= grp_max;
                        if (beat_sub == SUB_LAST) begin
                            bank_q[~front_q][beat_col] <= col_val;
                        end
                        if (last_bin) begin
                            ready_q  <= 1'b1;
                            wstate_q <= fft_eop ? W_HOLD : W_SKIP;
                        end else if (fft_eop) begin
                            err_q    <= 1'b1;
                            wstate_q <= W_IDLE;
                        end else begin
                            wstate_q <= W_CAP;
                            if (beat_sub == SUB_LAST) begin
                                sub_q <= '0;
                                col_q <= beat_col + 1'b1;
                            end else begin
                                sub_q <= beat_sub + 1'b1;
                                col_q <= beat_col;
                            end
                        end
                    end
                end
                W_SKIP: begin
                    if (fft_valid && fft_eop) begin
                        wstate_q <= W_HOLD;
                    end
                end
                W_HOLD: begin
                    if (fft_valid && fft_sop && ready_q) begin
                        drop_q <= 1'b1;
                    end
                    // The swap may already have happened while trailing bins were skipped.
                    if (swap || !ready_q) begin
                        wstate_q <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Column is fetched on entry to R_FETCH so rd_valid follows data_req by one cycle;
    // front_d lets a same-cycle swap feed the new bank.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rstate_q   <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (rstate_q)
                R_IDLE: begin
                    if (data_req) begin
                        rd_data_q  <= bank_q[front_d][rd_cnt_q];
                        rd_valid_q <= 1'b1;
                        rstate_q   <= R_FETCH;
                    end
                end
                R_FETCH: rstate_q <= R_WAIT;
                R_WAIT: begin
                    if (wr_over) begin
                        rd_cnt_q <= (rd_cnt_q == COL_LAST) ? '0 : rd_cnt_q + 1'b1;
                        rstate_q <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_cnt      = rd_cnt_q;
    assign frame_ready = ready_q;
    assign frame_drop  = drop_q;
    assign frame_err   = err_q;

endmodule
